// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } mem_ctrl_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int MEM_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word port between the data-memory controller and the SDRAM controller.
interface data_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mreq;
  logic            mwe;
  logic [XLEN-3:0] maddr;
  logic [XLEN-1:0] mwdata;
  logic [3:0]      mbe;
  logic            mack;
  logic            mrvalid;
  logic [XLEN-1:0] mrdata;

  modport master (
    output mreq, mwe, maddr, mwdata, mbe,
    input  mack, mrvalid, mrdata
  );

  modport slave (
    input  mreq, mwe, maddr, mwdata, mbe,
    output mack, mrvalid, mrdata
  );
endinterface

// File: rtl/data_mem_ctrl_mem_align.sv
// Byte-lane steering, byte enables, load extension and legality check.
// Purely combinational; the caller chooses live or latched access fields.
module mem_align
  import data_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      mbe,
  output logic [XLEN-1:0] mwdata,
  output logic [XLEN-1:0] rdata_ext,
  output logic            bad
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    mbe       = 4'b0000;
    mwdata    = wdata;
    rdata_ext = '0;
    bad       = 1'b0;
    case (funct3)
      LB: begin
        mbe       = 4'b0001 << addr_lo;
        mwdata    = {(XLEN/8){wdata[7:0]}};
        rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      LH: begin
        mbe       = addr_lo[1] ? 4'b1100 : 4'b0011;
        mwdata    = {(XLEN/16){wdata[15:0]}};
        rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        bad       = addr_lo[0];
      end
      LW: begin
        mbe       = 4'b1111;
        rdata_ext = shifted;
        bad       = |addr_lo;
      end
      LBU: begin
        mbe       = 4'b0001 << addr_lo;
        rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
        bad       = is_store;
      end
      LHU: begin
        mbe       = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
        bad       = is_store | addr_lo[0];
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: runs one load/store on the SDRAM word
// port and pulses mem_access_done so the hazard unit can release the stall.
//
// state   | meaning
// IDLE    | waiting for a load/store with SDRAM ready
// REQ     | mreq high, bus fields held until mack
// WAIT_RD | load accepted, waiting for mrvalid
// DONE    | one-cycle completion pulse, results valid
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC,
  parameter int TO_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              mem_access_done,
  output logic              misaligned,
  output logic              bus_err,
  data_mem_ctrl_if.master   mbus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  mem_ctrl_state_t state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic            st_q;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q;
  logic            err_q;
  logic [TO_W-1:0] cnt_q;

  logic            in_idle;
  logic            in_req;
  logic            start;
  logic            timeout;
  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic            al_st;
  logic [3:0]      al_mbe;
  logic [XLEN-1:0] al_mwdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_bad;

  assign in_idle = (state_q == IDLE);
  assign in_req  = (state_q == REQ);
  assign start   = (mem_rd | mem_wr) & sdram_init_done;
  assign timeout = (cnt_q == TO_LAST);

  // Legality is judged on the live inputs in IDLE; afterwards everything
  // comes from the latched copy so pipeline changes cannot leak in.
  assign al_f3 = in_idle ? funct3    : f3_q;
  assign al_lo = in_idle ? addr[1:0] : addr_q[1:0];
  assign al_st = in_idle ? mem_wr    : st_q;

  mem_align #(.XLEN(XLEN)) u_align (
    .funct3    (al_f3),
    .addr_lo   (al_lo),
    .is_store  (al_st),
    .wdata     (wdata_q),
    .rword     (mbus.mrdata),
    .mbe       (al_mbe),
    .mwdata    (al_mwdata),
    .rdata_ext (al_rdata),
    .bad       (al_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = al_bad ? DONE : REQ;
        end
      end
      REQ: begin
        if (timeout) begin
          state_d = DONE;
        end else if (mbus.mack) begin
          state_d = st_q ? DONE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (timeout || mbus.mrvalid) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            st_q    <= mem_wr;
            mis_q   <= al_bad;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
          end
        end
        REQ, WAIT_RD: begin
          cnt_q <= cnt_q + TO_W'(1);
          if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (state_q == WAIT_RD && mbus.mrvalid) begin
            rdata_q <= al_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_access_done = (state_q == DONE);
  assign misaligned      = mem_access_done & mis_q;
  assign bus_err         = mem_access_done & err_q;
  assign rdata           = rdata_q;

  assign mbus.mreq   = in_req;
  assign mbus.mwe    = in_req & st_q;
  assign mbus.maddr  = in_req ? addr_q[XLEN-1:2] : '0;
  assign mbus.mwdata = in_req ? al_mwdata : '0;
  assign mbus.mbe    = in_req ? al_mbe : 4'b0000;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with an SDRAM word-port responder.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int TOC  = 1024;

  logic        clk, rst_n, sdram_init_done, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        mem_access_done, misaligned, bus_err;

  data_mem_ctrl_if #(.XLEN(XLEN)) mbus ();

  data_mem_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(TOC), .TO_W(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .funct3          (funct3),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .mem_access_done (mem_access_done),
    .misaligned      (misaligned),
    .bus_err         (bus_err),
    .mbus            (mbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    int          nreq;
    logic [29:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mwdata;
    logic        mwe;
    logic        stable;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    logic        pulse1;
  } obs_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference: access size from funct3[1:0], signedness from funct3[2].
  function automatic void ref_model(input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] word, output logic bad,
                                    output logic [3:0] be, output logic [31:0] wv,
                                    output logic [31:0] rv);
    int size, off;
    logic [31:0] mask, val;
    off  = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    be = '0; wv = '0; rv = '0; bad = 1'b1;
    if (size == 0) return;
    bad = (f3[2] && (st || size == 4)) || (off % size != 0);
    be  = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) wv[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    val  = (word >> (8*off)) & mask;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    rv = val;
  endfunction

  // Issues one access and plays the SDRAM controller; mack after mack_dly
  // REQ cycles (negative: never), read data rv_dly cycles after mack.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int mack_dly, input int rv_dly,
                           input logic [31:0] word, output obs_t o);
    int ack_c;
    o.lat = -1; o.nreq = 0; o.maddr = '0; o.mbe = '0; o.mwdata = '0; o.mwe = 1'b0;
    o.stable = 1'b1; o.rdata = '0; o.mis = 1'b0; o.err = 1'b0; o.pulse1 = 1'b0;
    ack_c = -1;
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 1; c <= TOC + 100; c++) begin
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0;
      funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      mbus.mack = 1'b0; mbus.mrvalid = 1'b0; mbus.mrdata = $urandom;
      if (mem_access_done) begin
        o.lat = c; o.rdata = rdata; o.mis = misaligned; o.err = bus_err;
        break;
      end
      if (mbus.mreq) begin
        if (o.nreq == 0) begin
          o.maddr = mbus.maddr; o.mbe = mbus.mbe; o.mwdata = mbus.mwdata; o.mwe = mbus.mwe;
        end else if (mbus.maddr !== o.maddr || mbus.mbe !== o.mbe ||
                     mbus.mwdata !== o.mwdata || mbus.mwe !== o.mwe) begin
          o.stable = 1'b0;
        end
        if (o.nreq == mack_dly) begin
          // Data offered alongside mack must be ignored.
          mbus.mack = 1'b1; mbus.mrvalid = 1'b1; mbus.mrdata = ~word; ack_c = c;
        end
        o.nreq++;
      end else if (ack_c > 0 && c - ack_c == rv_dly) begin
        mbus.mrvalid = 1'b1; mbus.mrdata = word;
      end
    end
    mbus.mack = 1'b0; mbus.mrvalid = 1'b0;
    @(negedge clk);
    o.pulse1 = !mem_access_done;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({mbus.mreq, mem_access_done, misaligned, bus_err, mbus.mwe} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000",
                         {mbus.mreq, mem_access_done, misaligned, bus_err, mbus.mwe});
    end
    n_checks++;
    if (rdata !== 32'h0 || mbus.mwdata !== 32'h0 || mbus.maddr !== 30'h0 || mbus.mbe !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h mwdata %h maddr %h mbe %h required zeros",
                         rdata, mbus.mwdata, mbus.maddr, mbus.mbe);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mbus.mreq !== 1'b0 || mem_access_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: mreq %b done %b required 0 0", mbus.mreq, mem_access_done);
    end
  endtask

  task automatic test_sw();
    obs_t o;
    do_access(1'b0, 1'b1, SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1, 32'h0, o);
    n_checks++;
    if (o.maddr !== 30'h40 || o.mbe !== 4'b1111 || o.mwe !== 1'b1) begin
      n_fail++; $display("FAIL sw_bus: maddr %h mbe %b mwe %b required 40 1111 1", o.maddr, o.mbe, o.mwe);
    end
    n_checks++;
    if (o.mwdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_mwdata: got %h required deadbeef", o.mwdata);
    end
    n_checks++;
    if (o.lat !== 2 || o.pulse1 !== 1'b1 || o.nreq !== 1) begin
      n_fail++; $display("FAIL sw_timing: lat %0d pulse1 %b nreq %0d required 2 1 1", o.lat, o.pulse1, o.nreq);
    end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    do_access(1'b1, 1'b0, LB, 32'h0000_0103, 32'h0, 0, 3, 32'h80FF_1234, o);
    n_checks++;
    if (o.rdata !== 32'hFFFF_FF80 || o.lat !== 5 || o.mbe !== 4'b1000) begin
      n_fail++; $display("FAIL lb: rdata %h lat %0d mbe %b required ffffff80 5 1000", o.rdata, o.lat, o.mbe);
    end
    do_access(1'b1, 1'b0, LBU, 32'h0000_0103, 32'h0, 0, 3, 32'h80FF_1234, o);
    n_checks++;
    if (o.rdata !== 32'h0000_0080 || o.lat !== 5 || o.pulse1 !== 1'b1) begin
      n_fail++; $display("FAIL lbu: rdata %h lat %0d pulse1 %b required 00000080 5 1", o.rdata, o.lat, o.pulse1);
    end
  endtask

  task automatic test_sh_lh();
    obs_t o;
    do_access(1'b0, 1'b1, SH, 32'h0000_0202, 32'h0000_ABCD, 1, 1, 32'h0, o);
    n_checks++;
    if (o.mbe !== 4'b1100 || o.mwdata !== 32'hABCD_ABCD || o.stable !== 1'b1 || o.lat !== 3) begin
      n_fail++; $display("FAIL sh: mbe %b mwdata %h stable %b lat %0d required 1100 abcdabcd 1 3",
                         o.mbe, o.mwdata, o.stable, o.lat);
    end
    do_access(1'b1, 1'b0, LH, 32'h0000_0201, 32'h0, 0, 1, 32'h0, o);
    n_checks++;
    if (o.nreq !== 0 || o.lat !== 1 || o.mis !== 1'b1 || o.err !== 1'b0) begin
      n_fail++; $display("FAIL lh_misaligned: nreq %0d lat %0d mis %b err %b required 0 1 1 0",
                         o.nreq, o.lat, o.mis, o.err);
    end
  endtask

  task automatic test_init_gate();
    int bad_cycles;
    bad_cycles = 0;
    @(negedge clk);
    sdram_init_done = 1'b0; mem_rd = 1'b1; funct3 = LW; addr = 32'h0000_0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mbus.mreq !== 1'b0 || mem_access_done !== 1'b0) bad_cycles++;
    end
    n_checks++;
    if (bad_cycles != 0) begin
      n_fail++; $display("FAIL init_gate_stall: %0d cycles with mreq/done set, required 0", bad_cycles);
    end
    sdram_init_done = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0;
    n_checks++;
    if (mbus.mreq !== 1'b1 || mbus.maddr !== 30'h4) begin
      n_fail++; $display("FAIL init_gate_start: mreq %b maddr %h required 1 4", mbus.mreq, mbus.maddr);
    end
    mbus.mack = 1'b1;
    @(negedge clk);
    mbus.mack = 1'b0; mbus.mrvalid = 1'b1; mbus.mrdata = 32'h1234_5678;
    @(negedge clk);
    mbus.mrvalid = 1'b0;
    n_checks++;
    if (mem_access_done !== 1'b1 || rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL init_gate_load: done %b rdata %h required 1 12345678", mem_access_done, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1'b1, 1'b0, LW, 32'h0000_0300, 32'h0, -1, 1, 32'h0, o);
    n_checks++;
    if (o.nreq !== TOC || o.lat !== TOC + 1) begin
      n_fail++; $display("FAIL timeout_timing: nreq %0d lat %0d required %0d %0d", o.nreq, o.lat, TOC, TOC + 1);
    end
    n_checks++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.mis !== 1'b0 || o.pulse1 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_flags: err %b rdata %h mis %b pulse1 %b required 1 0 0 1",
                         o.err, o.rdata, o.mis, o.pulse1);
    end
    do_access(1'b0, 1'b1, SW, 32'h0000_0004, 32'h0102_0304, 0, 1, 32'h0, o);
    n_checks++;
    if (o.lat !== 2 || o.err !== 1'b0 || o.maddr !== 30'h1) begin
      n_fail++; $display("FAIL timeout_recover: lat %0d err %b maddr %h required 2 0 1", o.lat, o.err, o.maddr);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int late_done;
    @(negedge clk);
    mem_rd = 1'b1; funct3 = LW; addr = 32'h0000_0040;
    @(negedge clk);
    mem_rd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mbus.mreq !== 1'b0 || mem_access_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_req: mreq %b done %b required 0 0", mbus.mreq, mem_access_done);
    end
    @(negedge clk); rst_n = 1'b1;
    mem_rd = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0; mbus.mack = 1'b1;
    @(negedge clk);
    mbus.mack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mbus.mreq !== 1'b0 || mem_access_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_wait: mreq %b done %b required 0 0", mbus.mreq, mem_access_done);
    end
    @(negedge clk);
    rst_n = 1'b1; mbus.mrvalid = 1'b1; mbus.mrdata = 32'hCAFE_F00D;
    late_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mbus.mrvalid = 1'b0;
      if (mem_access_done !== 1'b0 || mbus.mreq !== 1'b0) late_done++;
    end
    n_checks++;
    if (late_done != 0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL late_mrvalid: %0d busy cycles rdata %h required 0 0", late_done, rdata);
    end
    do_access(1'b0, 1'b1, SW, 32'h0000_0080, 32'h5566_7788, 0, 1, 32'h0, o);
    n_checks++;
    if (o.lat !== 2 || o.mwdata !== 32'h5566_7788 || o.maddr !== 30'h20 || o.pulse1 !== 1'b1) begin
      n_fail++; $display("FAIL sw_after_reset: lat %0d mwdata %h maddr %h pulse1 %b required 2 55667788 20 1",
                         o.lat, o.mwdata, o.maddr, o.pulse1);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic rd, wr, st, bad;
    logic [2:0] f3;
    logic [31:0] a, wd, word, wv, rv;
    logic [3:0] be;
    int md, rvd, exp_lat;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      st = wr;
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom; word = $urandom;
      md = $urandom_range(0, 3); rvd = $urandom_range(1, 4);
      ref_model(st, f3, a, wd, word, bad, be, wv, rv);
      do_access(rd, wr, f3, a, wd, md, rvd, word, o);
      n_checks++;
      if (bad) begin
        if (o.nreq !== 0 || o.lat !== 1 || {o.mis, o.err, o.pulse1} !== 3'b101) begin
          n_fail++; $display("FAIL rnd_illegal f3=%b a=%h st=%b: nreq %0d lat %0d mis/err/pulse %b required 0 1 101",
                             f3, a, st, o.nreq, o.lat, {o.mis, o.err, o.pulse1});
        end
      end else begin
        exp_lat = st ? md + 2 : md + rvd + 2;
        if (o.nreq !== md + 1 || o.lat !== exp_lat || {o.mis, o.err, o.pulse1, o.stable} !== 4'b0011) begin
          n_fail++; $display("FAIL rnd_timing f3=%b a=%h st=%b: nreq %0d lat %0d flags %b required %0d %0d 0011",
                             f3, a, st, o.nreq, o.lat, {o.mis, o.err, o.pulse1, o.stable}, md + 1, exp_lat);
        end
        n_checks++;
        if (o.maddr !== a[31:2] || o.mbe !== be || o.mwe !== st) begin
          n_fail++; $display("FAIL rnd_bus f3=%b a=%h: maddr %h mbe %b mwe %b required %h %b %b",
                             f3, a, o.maddr, o.mbe, o.mwe, a[31:2], be, st);
        end
        n_checks++;
        if (st ? (o.mwdata !== wv) : (o.rdata !== rv)) begin
          n_fail++; $display("FAIL rnd_data f3=%b a=%h st=%b: mwdata %h rdata %h required %h",
                             f3, a, st, o.mwdata, o.rdata, st ? wv : rv);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sdram_init_done = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0;
    mbus.mack = 1'b0; mbus.mrvalid = 1'b0; mbus.mrdata = '0;
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh_lh();
    test_init_gate();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
